mem_stage_ls: RTL
=================

Name: mem_stage_ls

Overview:
- Parametrised successor to the pass-through MEM stage of the 5-stage pipeline; sits between EX and WB.
- Passes ALU results through to WB with one registered cycle.
- Executes loads/stores over a req/ack data bus: big-endian byte-lane select, load sign/zero extension, pipeline stall while the bus is busy, and timeout abort.

Parameters:
- ADDR_W, 32, data bus address width.
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT_CYC, 255, max BUSY cycles waiting for bus_ack before abort (1..65535).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid_i  in  1  EX→MEM instruction valid.
- ans_i  in  32  ALU result; used as the write-back value for non-memory ops.
- write_enable_i  in  1  register write request.
- write_addr_i  in  REG_ADDR_W  destination register.
- mem_op_i  in  4  0000 none; 0001 LB; 0010 LBU; 0011 LH; 0100 LHU; 0101 LW; 1001 SB; 1010 SH; 1011 SW; other codes = none.
- mem_addr_i  in  ADDR_W  effective address.
- store_data_i  in  32  store source register value.
- bus_req_o  out  1  bus request, registered.
- bus_we_o  out  1  1 = write.
- bus_sel_o  out  4  byte enables; bit3 = bits 31:24.
- bus_addr_o  out  ADDR_W  word-aligned address (low 2 bits = 0).
- bus_wdata_o  out  32  lane-replicated store data.
- bus_rdata_i  in  32  read data, valid with bus_ack_i.
- bus_ack_i  in  1  completion strobe, one cycle.
- stall_o  out  1  freeze EX/MEM and upstream stages, combinational.
- ans_o  out  32  write-back value, registered.
- write_enable_o  out  1  write-back enable, registered.
- write_addr_o  out  REG_ADDR_W  write-back register, registered.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state=IDLE; bus_req_o, bus_we_o, write_enable_o, bus_err_o = 0; bus_sel_o=0; ans_o, write_addr_o, bus_addr_o, bus_wdata_o = 0; timeout counter = 0. Reset mid-BUSY aborts the transfer immediately; a late ack after reset is ignored.
- States: IDLE, BUSY.
- IDLE, no in_valid_i or op none:
  - Next edge: ans_o←ans_i, write_enable_o←write_enable_i & in_valid_i, write_addr_o←write_addr_i.
  - Latency 1, stall_o=0.
- IDLE, in_valid_i & memory op:
  - stall_o=1.
  - Next edge: latch op, register, and sub-word offset; drive bus_req_o=1, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o; write_enable_o←0; go BUSY; counter←0.
- Lane select, big-endian, off = mem_addr_i[1:0]:
  - Byte: sel=4'b1000>>off.
  - Half: sel=4'b1100 when off[1]=0, else 4'b0011.
  - Word: sel=4'b1111.
  - Store data is replicated: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- BUSY, bus_ack_i=0:
  - Bus outputs held stable; stall_o=1; counter++.
- BUSY, bus_ack_i=1:
  - stall_o=0 this cycle.
  - Next edge: bus_req_o←0; state←IDLE.
  - Load: ans_o←extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW); write_enable_o←latched we; write_addr_o←latched addr.
  - Store: write_enable_o←0.
  - Total load-use latency = bus wait + 1.
- Ack in the same cycle the counter reaches TIMEOUT_CYC-1: treated as success; the ack has priority over timeout.
- Timeout (counter == TIMEOUT_CYC-1, no ack):
  - Next edge: bus_req_o←0, bus_err_o←1 for 1 cycle, write_enable_o←0, state←IDLE.
  - stall_o=0 in the final cycle.
- bus_ack_i in IDLE is ignored.
- in_valid_i is sampled only in IDLE with stall_o=0, or on the release cycle; a new instruction on the release cycle is accepted next edge per the IDLE rules.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword with off[0]=1 or word with off≠0: no bus request, stall_o=0.
  - Next edge: write_enable_o←0, bus_err_o pulses 1 cycle, state stays IDLE.
- Undefined:
  - Halfword uses off[1] only; word ignores off.
  - bus_err_o is driven only by timeout.

Test Plan:
- Non-memory op: ans_i=0x12345678, we=1, waddr=3 → next cycle ans_o=0x12345678, write_enable_o=1, write_addr_o=3, stall_o never 1.
- LB addr=0x1001, rdata=0x00F00000, ack after 2 wait cycles → bus_sel_o=4'b0100, stall_o high 3 cycles, ans_o=0xFFFFFFF0; LBU same → 0x000000F0.
- SH addr=0x2002, data=0xAAAABEEF → bus_we_o=1, bus_sel_o=4'b0011, bus_wdata_o=0xBEEFBEEF, write_enable_o=0 after ack.
- LW, no ack, TIMEOUT_CYC=4 → bus_req_o drops after 4 BUSY cycles, bus_err_o single pulse, write_enable_o=0, stall_o released.
- rst asserted mid-BUSY, then ack → all outputs at reset values, ack ignored, next instruction proceeds normally.
- MEM_ALIGN_CHECK_EN defined, LW addr=0x3002 → no bus_req_o, bus_err_o pulse, write_enable_o=0.

Source files
------------

// File: rtl/mem_stage_ls.sv
// ============================================================================
// mem_stage_ls : MEM stage with ALU pass-through and req/ack load/store unit
//   (big-endian lanes, load extension, stall, timeout). Optional macro:
//   MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_ls #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [31:0]           ans_i,
  input  logic                  write_enable_i,
  input  logic [REG_ADDR_W-1:0] write_addr_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [3:0]            bus_sel_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [31:0]           bus_wdata_o,
  input  logic [31:0]           bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic                  stall_o,
  output logic [31:0]           ans_o,
  output logic                  write_enable_o,
  output logic [REG_ADDR_W-1:0] write_addr_o,
  output logic                  bus_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LBU = 4'b0010;
  localparam logic [3:0] OP_LH  = 4'b0011;
  localparam logic [3:0] OP_LHU = 4'b0100;
  localparam logic [3:0] OP_LW  = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [3:0]            bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [31:0]           bus_wdata_q, bus_wdata_d;
  logic [31:0]           ans_q, ans_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [1:0]            off_q, off_d;
  logic                  lwen_q, lwen_d;
  logic [REG_ADDR_W-1:0] lwaddr_q, lwaddr_d;

  logic                  is_mem;
  logic                  is_store;
  logic [1:0]            size;
  logic [1:0]            off;
  logic                  misalign;
  logic [3:0]            sel_new;
  logic [31:0]           wdata_new;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_val;
  logic                  stall_c;

  assign off = mem_addr_i[1:0];

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    size     = SZ_WORD;
    case (mem_op_i)
      OP_LB, OP_LBU: size = SZ_BYTE;
      OP_LH, OP_LHU: size = SZ_HALF;
      OP_LW:         size = SZ_WORD;
      OP_SB: begin size = SZ_BYTE; is_store = 1'b1; end
      OP_SH: begin size = SZ_HALF; is_store = 1'b1; end
      OP_SW: begin size = SZ_WORD; is_store = 1'b1; end
      default:       is_mem = 1'b0;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_mem &&
                    (((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Big-endian: byte 0 of a word lives in bits 31:24.
  always_comb begin
    sel_new   = 4'b1111;
    wdata_new = store_data_i;
    case (size)
      SZ_BYTE: begin
        sel_new   = 4'b1000 >> off;
        wdata_new = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        sel_new   = off[1] ? 4'b0011 : 4'b1100;
        wdata_new = {2{store_data_i[15:0]}};
      end
      default: begin
        sel_new   = 4'b1111;
        wdata_new = store_data_i;
      end
    endcase
  end

  always_comb begin
    rd_byte = bus_rdata_i[31:24];
    case (off_q)
      2'd0:    rd_byte = bus_rdata_i[31:24];
      2'd1:    rd_byte = bus_rdata_i[23:16];
      2'd2:    rd_byte = bus_rdata_i[15:8];
      default: rd_byte = bus_rdata_i[7:0];
    endcase
    rd_half = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    case (op_q)
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'd0, rd_byte};
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'd0, rd_half};
      default: load_val = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ans_d       = ans_q;
    wen_d       = wen_q;
    waddr_d     = waddr_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    lwen_d      = lwen_q;
    lwaddr_d    = lwaddr_q;
    stall_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ans_d   = ans_i;
        wen_d   = write_enable_i & in_valid_i;
        waddr_d = write_addr_i;
        if (in_valid_i && is_mem && misalign) begin
          wen_d = 1'b0;
          err_d = 1'b1;
        end else if (in_valid_i && is_mem) begin
          stall_c     = 1'b1;
          wen_d       = 1'b0;
          op_d        = mem_op_i;
          off_d       = off;
          lwen_d      = write_enable_i;
          lwaddr_d    = write_addr_i;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_sel_d   = sel_new;
          bus_addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
          bus_wdata_d = wdata_new;
          cnt_d       = 16'd0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Ack wins over a timeout landing on the same cycle.
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (op_q[3]) begin
            wen_d = 1'b0;
          end else begin
            ans_d   = load_val;
            wen_d   = lwen_q;
            waddr_d = lwaddr_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          wen_d     = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 32'd0;
      ans_q       <= 32'd0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= 16'd0;
      op_q        <= 4'd0;
      off_q       <= 2'd0;
      lwen_q      <= 1'b0;
      lwaddr_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ans_q       <= ans_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      lwen_q      <= lwen_d;
      lwaddr_q    <= lwaddr_d;
    end
  end

  assign stall_o        = stall_c;
  assign bus_req_o      = bus_req_q;
  assign bus_we_o       = bus_we_q;
  assign bus_sel_o      = bus_sel_q;
  assign bus_addr_o     = bus_addr_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign ans_o          = ans_q;
  assign write_enable_o = wen_q;
  assign write_addr_o   = waddr_q;
  assign bus_err_o      = err_q;

endmodule

`default_nettype wire
